aes_top_compact: RTL and testbench
==================================

Name: aes_top_compact

Overview:
- Compact FPGA top level: AES-128 encryption of one of four hard-wired test vectors, driven by two push buttons and 4 switches, with status and result on 8 LEDs.
- Iterative core: one round per clock, on-the-fly key expansion, algebraic S-box (no 256-entry tables).
- Board-level wrapper; no other I/O.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the button synchronisers.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset. Synchronous and active-high despite the codebase name: 1 = reset.
- btnC  in  1  start button (asynchronous, level).
- btnU  in  1  display-advance button (asynchronous, level).
- sw  in  4  vector select, sampled on start.
- led  out  8  [7] done, [6] pass, [5] busy, [4] 0, [3:0] selected ciphertext nibble.

Behaviour:
- Reset (rst_n=1 at clk edge) sets FSM=IDLE, done=0, pass=0, busy=0, nibble pointer=0, ciphertext register=0. All led bits read 0. This applies even mid-encryption; any in-flight result is discarded.
- Buttons:
  - Each button passes through a SYNC_STAGES synchroniser and a rising-edge detector, giving a one-cycle pulse per press.
  - No debounce; the bench drives clean pulses.
- Vectors, selected by sw[1:0]; sw[3:2] is ignored (key / plaintext -> ciphertext, 128-bit, byte 0 = MSB):
  - 0: FIPS-197 C.1. Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - 1: FIPS-197 App. B. Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
  - 2: key 0, pt 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - 3: key 2b7e...4f3c, pt 6bc1bee22e409f96e93d7e117393172a -> 3ad77bb40d7a3660a89ecaf32466ef97.
- FSM states IDLE, RUN, DONE:
  - IDLE or DONE + start pulse -> RUN:
    - latch key/pt for the current sw[1:0];
    - state = pt XOR key; round counter = 1; done=0; pass=0; busy=1.
  - RUN, each cycle: apply one round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with the next round key derived combinationally from the previous one (rcon 01,02,04,08,10,20,40,80,1b,36).
    - Round 10 omits MixColumns.
    - After round 10, go to DONE.
  - Entering DONE:
    - ciphertext register = state; done=1; busy=0;
    - pass=1 iff ciphertext equals the stored expected value for the latched vector;
    - nibble pointer resets to 0.
  - Latency: done rises exactly 10 cycles after the cycle in which the start pulse is seen. Total from btnC rising to led[7]=1 is ≤ 14 cycles.
  - A start pulse during RUN is ignored. A start pulse in DONE re-runs, clearing done/pass for the 10 cycles.
  - sw changes during RUN have no effect.
- Display:
  - led[3:0] = ciphertext nibble at the pointer; pointer 0 = bits [127:124].
  - A btnU pulse increments the pointer mod 32 (31 wraps to 0).
  - btnU is ignored outside DONE.
  - Simultaneous btnC and btnU pulses: start wins, pointer is not advanced.
- S-box: GF(2^8) inverse (poly 0x11b, inverse of 0 = 0) followed by the FIPS affine transform with constant 0x63.

Decomposition:
- Package aes_pkg:
  - functions xtime, gf_mul, sbox, sub_word, mix_column;
  - rcon constants;
  - the four key/pt/ct vector constants;
  - FSM state enum.
- One sub-module, aes128_iter_core:
  - inputs start, key, pt;
  - outputs ct, done;
  - contains the round/key datapath and counter.
- Top holds the synchronisers, FSM glue, vector ROM, compare logic and LED mux.

Test Plan:
- Reset held 2 cycles, then released, sw=0 -> led==8'h00.
- sw=0, btnC pulsed 2 cycles -> led[7] rises within 14 cycles; led[6]=1; led[3:0]=4'h6. Five btnU pulses -> led[3:0] = 6, 9, c, 4, e, 0 in turn.
- Repeat for sw=1, 2, 3 -> pass=1, first nibble 3, 6, 3. Observing all 32 nibbles reproduces the full ciphertext.
- btnC pulsed again during RUN -> completion time unchanged; single done rise.
- rst_n asserted mid-RUN -> led==0 next cycle. New start after release -> correct result, pass=1.
- sw=4'b0101 -> behaves as vector 1 (pass=1). 32 btnU pulses -> pointer wraps to nibble 0.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 arithmetic helpers, round constants, the four board test vectors
// and the board-level FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (p & {8{b[i]}});
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as x^254 (square-and-multiply), which maps 0 to 0, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] vec_key(input logic [1:0] sel);
    logic [127:0] k;
    case (sel)
      2'd0:    k = 128'h000102030405060708090a0b0c0d0e0f;
      2'd1:    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      2'd2:    k = 128'h00000000000000000000000000000000;
      2'd3:    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      default: k = 128'h00000000000000000000000000000000;
    endcase
    return k;
  endfunction

  function automatic logic [127:0] vec_pt(input logic [1:0] sel);
    logic [127:0] p;
    case (sel)
      2'd0:    p = 128'h00112233445566778899aabbccddeeff;
      2'd1:    p = 128'h3243f6a8885a308d313198a2e0370734;
      2'd2:    p = 128'h00000000000000000000000000000000;
      2'd3:    p = 128'h6bc1bee22e409f96e93d7e117393172a;
      default: p = 128'h00000000000000000000000000000000;
    endcase
    return p;
  endfunction

  function automatic logic [127:0] vec_ct(input logic [1:0] sel);
    logic [127:0] c;
    case (sel)
      2'd0:    c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    c = 128'h3925841d02dc09fbdc118597196a0b32;
      2'd2:    c = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      2'd3:    c = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      default: c = 128'h00000000000000000000000000000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// done is a one-cycle strobe in the final round; ct is valid only while done is high.
module aes128_iter_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic [127:0] ct,
  output logic         done
);

  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;

  logic [31:0]  kt_s;
  logic [127:0] rk_next_s;
  logic [127:0] sb_s, sr_s, mc_s, round_out_s;
  logic         last_s;

  assign last_s = (round_q == LAST_ROUND);

  // Next round key from the current one; round_q selects the rcon.
  always_comb begin
    kt_s = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon(round_q), 24'h000000};
    rk_next_s[127:96] = rk_q[127:96] ^ kt_s;
    rk_next_s[95:64]  = rk_q[95:64]  ^ rk_next_s[127:96];
    rk_next_s[63:32]  = rk_q[63:32]  ^ rk_next_s[95:64];
    rk_next_s[31:0]   = rk_q[31:0]   ^ rk_next_s[63:32];
  end

  // Byte b of the state sits at [127-8b -: 8]; column c holds bytes 4c..4c+3.
  always_comb begin
    sb_s = '0;
    sr_s = '0;
    mc_s = '0;
    for (int b = 0; b < 16; b++) begin
      sb_s[127-8*b -: 8] = sbox(state_q[127-8*b -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 32] = mix_column(sr_s[127-32*c -: 32]);
    end
    round_out_s = (last_s ? sr_s : mc_s) ^ rk_next_s;
  end

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    busy_d  = busy_q;
    if (busy_q) begin
      state_d = round_out_s;
      rk_d    = rk_next_s;
      if (last_s) begin
        round_d = 4'd0;
        busy_d  = 1'b0;
      end else begin
        round_d = round_q + 4'd1;
        busy_d  = 1'b1;
      end
    end else if (start) begin
      state_d = pt ^ key;
      rk_d    = key;
      round_d = 4'd1;
      busy_d  = 1'b1;
    end else begin
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rk_q    <= '0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      busy_q  <= busy_d;
    end
  end

  assign ct   = round_out_s;
  assign done = busy_q & last_s;

endmodule

// File: rtl/aes_top_compact.sv
// Board wrapper: button synchronisers, run/display FSM, vector ROM, result check
// and LED mux around the iterative AES-128 core.
module aes_top_compact
  import aes_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic [3:0] sw,
  output logic [7:0] led
);

  logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d, u_sync_q, u_sync_d;
  logic                   c_prev_q, c_prev_d, u_prev_q, u_prev_d;
  logic                   start_s, adv_s;

  state_e       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [127:0] ct_q, ct_d;
  logic [4:0]   ptr_q, ptr_d;
  logic         done_q, done_d, pass_q, pass_d, busy_q, busy_d;

  logic         core_start_s, core_done_s;
  logic [127:0] core_ct_s;
  logic         unused_sw_s;

  assign unused_sw_s = ^sw[3:2];

  always_comb begin
    c_sync_d = {c_sync_q[SYNC_STAGES-2:0], btnC};
    u_sync_d = {u_sync_q[SYNC_STAGES-2:0], btnU};
    c_prev_d = c_sync_q[SYNC_STAGES-1];
    u_prev_d = u_sync_q[SYNC_STAGES-1];
  end

  assign start_s = c_sync_q[SYNC_STAGES-1] & ~c_prev_q;
  assign adv_s   = u_sync_q[SYNC_STAGES-1] & ~u_prev_q;

  // Start has priority over display advance; a start during RUN is dropped.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ct_d         = ct_q;
    ptr_d        = ptr_q;
    done_d       = done_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    core_start_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_d      = ST_RUN;
          sel_d        = sw[1:0];
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          core_start_s = 1'b1;
        end else if (adv_s && (state_q == ST_DONE)) begin
          ptr_d = ptr_q + 5'd1;
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_RUN: begin
        if (core_done_s) begin
          state_d = ST_DONE;
          ct_d    = core_ct_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (core_ct_s == vec_ct(sel_q));
          ptr_d   = 5'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      c_sync_q <= '0;
      u_sync_q <= '0;
      c_prev_q <= 1'b0;
      u_prev_q <= 1'b0;
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      ct_q     <= '0;
      ptr_q    <= 5'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      c_sync_q <= c_sync_d;
      u_sync_q <= u_sync_d;
      c_prev_q <= c_prev_d;
      u_prev_q <= u_prev_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      ct_q     <= ct_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
    end
  end

  aes128_iter_core u_core (
    .clk   (clk),
    .rst   (rst_n),
    .start (core_start_s),
    .key   (vec_key(sw[1:0])),
    .pt    (vec_pt(sw[1:0])),
    .ct    (core_ct_s),
    .done  (core_done_s)
  );

  // Pointer p selects bits [127-4p -: 4], i.e. top index {~p, 2'b11}.
  assign led = {done_q, pass_q, busy_q, 1'b0, ct_q[{~ptr_q, 2'b11} -: 4]};

endmodule

// File: tb/tb_aes_top_compact.sv
// Directed bench for aes_top_compact: reset, all four vectors with full nibble
// readout and wrap, restart during RUN, reset mid-run and sw[3:2] aliasing.
module tb_aes_top_compact;

  logic       clk = 1'b0;
  logic       rst_n, btnC, btnU;
  logic [3:0] sw;
  logic [7:0] led;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CT3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  // btnC rises before edge 0, synchroniser output after edge 1, start seen
  // between edges 1 and 2, done registered 10 edges later at edge 12,
  // observed on the 13th falling edge.
  localparam int EXP_LAT = 13;

  aes_top_compact #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btnC  (btnC),
    .btnU  (btnU),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  task automatic press_u();
    @(negedge clk);
    btnU = 1'b1;
    repeat (2) @(negedge clk);
    btnU = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Press start; optionally change sw and re-press start while running.
  task automatic start_and_wait(input logic [3:0] sel, input logic [3:0] sw_mid,
                                input bit restart_mid, output int lat);
    bit seen_low;
    bit hit;
    sw       = sel;
    btnC     = 1'b1;
    lat      = -1;
    seen_low = 1'b0;
    hit      = 1'b0;
    for (int cyc = 1; cyc <= 40 && !hit; cyc++) begin
      @(negedge clk);
      if (cyc == 2) btnC = 1'b0;
      if (cyc == 5) begin
        sw = sw_mid;
        if (restart_mid) btnC = 1'b1;
      end
      if (cyc == 7) btnC = 1'b0;
      if (!led[7]) seen_low = 1'b1;
      else if (seen_low) begin
        hit = 1'b1;
        lat = cyc;
      end
    end
  endtask

  task automatic check_readout(input logic [3:0] sel, input logic [127:0] exp);
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (led[3:0] !== exp[127-4*i -: 4]) begin
        n_bad++;
        $display("FAIL nibble sw=%0h idx=%0d: got %h want %h", sel, i, led[3:0], exp[127-4*i -: 4]);
      end
      press_u();
    end
    n_vec++;
    if (led[3:0] !== exp[127:124]) begin
      n_bad++;
      $display("FAIL wrap sw=%0h: got %h want %h", sel, led[3:0], exp[127:124]);
    end
  endtask

  task automatic test_vector(input logic [3:0] sel, input logic [3:0] sw_mid,
                             input logic [127:0] exp);
    int lat;
    start_and_wait(sel, sw_mid, 1'b0, lat);
    n_vec++;
    if (lat != EXP_LAT) begin
      n_bad++;
      $display("FAIL latency sw=%0h: got %0d want %0d", sel, lat, EXP_LAT);
    end
    n_vec++;
    if (led[7:4] !== 4'b1100) begin
      n_bad++;
      $display("FAIL status sw=%0h: got %b want 1100", sel, led[7:4]);
    end
    check_readout(sel, exp);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; btnC = 1'b0; btnU = 1'b0; sw = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (led !== 8'h00) begin
      n_bad++;
      $display("FAIL reset: got %h want 00", led);
    end
  endtask

  task automatic test_restart_in_run();
    int lat;
    int drops;
    start_and_wait(4'h0, 4'h0, 1'b1, lat);
    n_vec++;
    if (lat != EXP_LAT) begin
      n_bad++;
      $display("FAIL restart latency: got %0d want %0d", lat, EXP_LAT);
    end
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!led[7]) drops++;
    end
    n_vec++;
    if (drops != 0) begin
      n_bad++;
      $display("FAIL restart single-done: got %0d low cycles want 0", drops);
    end
    n_vec++;
    if (led !== 8'hc6) begin
      n_bad++;
      $display("FAIL restart result: got %h want c6", led);
    end
  endtask

  task automatic test_reset_mid_run();
    sw   = 4'h3;
    btnC = 1'b1;
    repeat (2) @(negedge clk);
    btnC = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (led[7:5] !== 3'b001) begin
      n_bad++;
      $display("FAIL midrun busy: got %b want 001", led[7:5]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (led !== 8'h00) begin
      n_bad++;
      $display("FAIL midrun reset: got %h want 00", led);
    end
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (led !== 8'h00) begin
      n_bad++;
      $display("FAIL midrun discard: got %h want 00", led);
    end
  endtask

  initial begin
    test_reset();
    test_vector(4'h0, 4'h3, CT0);
    test_vector(4'h1, 4'h2, CT1);
    test_vector(4'h2, 4'h0, CT2);
    test_vector(4'h3, 4'h1, CT3);
    test_restart_in_run();
    test_reset_mid_run();
    test_vector(4'h3, 4'h3, CT3);
    test_vector(4'b0101, 4'b0101, CT1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
